// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with divide-by-zero and overflow resolved early.
module muldiv_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              op_q, op_d;
   logic [DATA_W-1:0]       opnd_q, opnd_d;
   logic [2*DATA_W-1:0]     acc_q, acc_d;
   logic                    neg_q, neg_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic [DATA_W-1:0]       result_q, result_d;

   function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic s);
      return s ? (~v + 1'b1) : v;
   endfunction

   // Operand signedness: MUL/MULH/DIV/REM both signed, MULHSU only rs1.
   logic              sa, sb, a_neg, b_neg, div_zero, div_ovf;
   logic [DATA_W-1:0] a_abs, b_abs;

   assign sa       = op[2] ? ~op[0] : (op != 3'b011);
   assign sb       = op[2] ? ~op[0] : (op[2:1] == 2'b00);
   assign a_neg    = sa & A[DATA_W-1];
   assign b_neg    = sb & B[DATA_W-1];
   assign a_abs    = cond_neg(A, a_neg);
   assign b_abs    = cond_neg(B, b_neg);
   assign div_zero = op[2] & (B == '0);
   assign div_ovf  = op[2] & ~op[0] & (A == {1'b1, {(DATA_W-1){1'b0}}}) & (B == '1);

   // acc holds {partial product high, multiplier} or {partial remainder, dividend/quotient}.
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_part;
   logic                div_ok;
   logic [DATA_W-1:0]   div_diff, div_rem;
   logic [2*DATA_W-1:0] prod_s;
   logic [DATA_W-1:0]   res_fin;

   assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign div_part = acc_q[2*DATA_W-1:DATA_W-1];
   assign div_ok   = (div_part >= {1'b0, opnd_q});
   assign div_diff = div_part[DATA_W-1:0] - opnd_q;
   assign div_rem  = div_ok ? div_diff : div_part[DATA_W-1:0];
   assign prod_s   = neg_q ? (~acc_q + 1'b1) : acc_q;

   always_comb begin
      res_fin = '0;
      if (op_q[2]) begin
         res_fin = op_q[1] ? cond_neg(acc_q[2*DATA_W-1:DATA_W], neg_q)
                           : cond_neg(acc_q[DATA_W-1:0], neg_q);
      end else begin
         res_fin = (op_q[1:0] == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op;
               if (div_zero) begin
                  acc_d   = {A, {DATA_W{1'b1}}};
                  neg_d   = 1'b0;
                  state_d = FINISH;
               end else if (div_ovf) begin
                  acc_d   = {{DATA_W{1'b0}}, A};
                  neg_d   = 1'b0;
                  state_d = FINISH;
               end else begin
                  // Remainder follows the dividend's sign; everything else the xor.
                  neg_d   = (op == 3'b110) ? a_neg : (a_neg ^ b_neg);
                  opnd_d  = op[2] ? b_abs : a_abs;
                  acc_d   = {{DATA_W{1'b0}}, (op[2] ? a_abs : b_abs)};
                  cnt_d   = CNT_W'(DATA_W);
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               if (op_q[2]) acc_d = {div_rem, acc_q[DATA_W-2:0], div_ok};
               else         acc_d = {mul_sum, acc_q[DATA_W-1:1]};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
            if (!abort) begin
               result_d = res_fin;
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, short path, abort, reset, back-to-back.
module tb_muldiv_unit;

   localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                          DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

   logic        clk, rst, start, abort;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy, done;
   logic [31:0] result;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int t0     = 0;
   int lat, bcnt;
   logic busy_at_done;

   muldiv_unit #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
      .A(A), .B(B), .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      #1;
      t0    = cyc;
      start = 1'b0; op = 3'b101; A = 32'hDEADBEEF; B = 32'h0BADF00D;
   endtask

   // lat = edges from start sample to done, or -1 if done never shows up.
   task automatic wait_done(input int maxc);
      lat = -1; bcnt = 0; busy_at_done = 1'bx;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = cyc - t0;
            busy_at_done = busy;
            break;
         end
         if (busy) bcnt++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      start_op(o, a, b);
      wait_done(40);
      check({tag, "_res"}, result, exp);
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; op = 3'b000; A = '0; B = '0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_result", result, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // MUL with latency and busy profile
      start_op(MUL, 32'd7, 32'hFFFFFFFD);
      check("mul_busy_e0", busy, 1'b1);
      wait_done(40);
      check("mul_res", result, 32'hFFFFFFEB);
      check("mul_lat", lat, 33);
      check("mul_busy_cycles", bcnt, 32);
      check("mul_busy_at_done", busy_at_done, 1'b0);
      @(posedge clk); #1;
      check("mul_done_pulse", done, 1'b0);

      run("mulh",   MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
      run("mulhu",  MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run("div_neg", DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run("rem_neg", REM,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run("divu",   DIVU,   32'd100,      32'd7,        32'd14,       33);
      run("remu",   REMU,   32'd100,      32'd7,        32'd2,        33);
      run("div_negb", DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);

      // short path
      run("divu_z",  DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run("rem_z",   REM,  32'd5,        32'd0,        32'd5,        1);
      run("div_ovf", DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run("rem_ovf", REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1);

      // start during CALC is ignored
      start_op(MUL, 32'd7, 32'hFFFFFFFD);
      repeat (5) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = DIVU; A = 32'd100; B = 32'd7;
      @(negedge clk);
      start = 1'b0;
      wait_done(40);
      check("ign_res", result, 32'hFFFFFFEB);
      check("ign_lat", lat, 33);
      wait_done(40);
      check("ign_no_second_done", lat, -1);

      // abort around cycle 10
      start_op(DIVU, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      wait_done(40);
      check("abort_no_done", lat, -1);
      check("abort_result_kept", result, 32'hFFFFFFEB);

      // back-to-back: second start issued in the done cycle
      start_op(DIVU, 32'd100, 32'd7);
      wait_done(40);
      check("b2b_first_res", result, 32'd14);
      check("b2b_first_lat", lat, 33);
      start_op(REMU, 32'd100, 32'd7);
      wait_done(40);
      check("b2b_second_res", result, 32'd2);
      check("b2b_second_lat", lat, 33);

      // asynchronous reset around cycle 20 of an op
      start_op(MUL, 32'd7, 32'hFFFFFFFD);
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_result", result, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run("post_rst", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1);
      run("post_rst_mul", MUL, 32'd6, 32'd9, 32'd54, 33);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV32M extension, parametrised in operand width. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per start pulse, computes the result one bit per cycle (shift-add multiply, restoring divide), and returns a registered result with a one-cycle done pulse. Divide-by-zero and signed-overflow cases are resolved on a short path.

## Interface
- n, 32, operand/result width (≥4, even)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- abort  in  1  cancel in-flight op (pipeline flush)
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  n  rs1 operand (dividend / multiplicand)
- B  in  n  rs2 operand (divisor / multiplier)
- busy  out  1  high while state≠IDLE
- done  out  1  registered one-cycle pulse, result valid
- result  out  n  registered result, held until next result load

## Operation
- States: IDLE, CALC, FINISH. Reset → IDLE, busy=0, done=0, result=0, internal registers 0.
- IDLE + start:
  - Latch op.
  - Latch |A| and |B| for the operands op treats as signed. MUL/MULH/DIV/REM: both signed. MULHSU: A only. MULHU/DIVU/REMU/MUL low word: unsigned treatment is equivalent.
  - Latch the result sign flag.
  - Load counter=n. Go to CALC.
- Short path, IDLE → FINISH directly:
  - divide op with B=0: quotient=all ones; remainder=A.
  - DIV/REM with A=100…0 and B=all ones: quotient=A; remainder=0.
- CALC, multiply: 2n-bit accumulator. Each cycle examines one multiplier bit, adds the shifted multiplicand and shifts.
- CALC, divide: restoring divide. Each cycle shifts one dividend bit into the n+1-bit partial remainder and trial-subtracts the divisor. The quotient bit is 1 if the remainder is non-negative, and the remainder is restored otherwise.
- Counter decrements each CALC cycle. At counter=1 (last iteration) go to FINISH.
- FINISH: load result in one cycle, set done=1, go to IDLE.
  - Multiply: negate the 2n-bit product if the sign flag is set. MUL takes the low n bits; MULH/MULHSU/MULHU take the high n bits.
  - DIV: quotient negated if sign(A)≠sign(B).
  - REM: remainder takes sign(A).
- start while busy=1 is ignored; no queueing.
- abort while busy=1 → IDLE next edge. No done is issued and result is unchanged. abort in IDLE has no effect; start in IDLE wins over abort.
- Arithmetic is modulo 2^n. No flags are produced.

## Timing
- Edge E0 samples start in IDLE.
- Normal path: E1..En perform n iterations, with En entering FINISH. E(n+1) loads result and asserts done. done is high for exactly the cycle after E(n+1). Latency is n+1 edges (33 at n=32).
- Short path: E1 loads result and asserts done; latency is 1 edge.
- done and busy are never high together. busy is high from E0+ until the FINISH edge.
- start is accepted in the same cycle done is high, which gives back-to-back issue with no bubble.
- Asynchronous rst at any point forces IDLE, busy=0, done=0, result=0 immediately, independent of clk. The first start after rst release is honoured normally.
- A, B and op may change after E0 without affecting the in-flight op.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → result 0xFFFFFFEB; done exactly 33 edges after start; busy high for 32 of those cycles, then low.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Division signs:
  - DIV 0xFFFFFFF9 (−7)/2 → 0xFFFFFFFD.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
- Short path (done 1 edge after start in every case):
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Control:
  - start pulsed again mid-CALC is ignored, and the first result is unchanged.
  - abort at cycle 10: no done; result keeps its previous value.
  - rst at cycle 20: outputs zero immediately.
  - A new start issued in the done cycle completes 33 edges later.
